// File: rtl/uart_pkg.sv
// Shared UART definitions: word width and the transmit-arbiter FSM state encoding.
package uart_pkg;

   localparam int DATA_BITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   int unsigned      sum_s;
   logic [IDX_W-1:0] slot_s;

   // Scan every slot once starting at ptr; the first requester found wins.
   always_comb begin
      hit    = 1'b0;
      idx    = '0;
      sum_s  = 32'd0;
      slot_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum_s  = (32'(ptr) + 32'(k)) % 32'(N_REQ);
         slot_s = IDX_W'(sum_s);
         if (!hit && req[slot_s]) begin
            hit = 1'b1;
            idx = slot_s;
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters,
// with a start timeout that drops a word the UART never picks up.
module uart_tx_arbiter #(
   parameter int DATA_BITS     = uart_pkg::DATA_BITS,
   parameter int N_REQ         = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_BITS-1:0] req_data,
   output logic [N_REQ-1:0]           req_accept,
   output logic [N_REQ-1:0]           req_done,
   output logic [N_REQ-1:0]           req_err,
   output logic [DATA_BITS-1:0]       TxData,
   output logic                       TxReq,
   input  logic                       TxBusy,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy
);
   import uart_pkg::*;

   localparam int               IDX_W    = $clog2(N_REQ);
   localparam int               CNT_W    = $clog2(START_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   arb_state_t           state_r;
   logic [IDX_W-1:0]     rr_ptr_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 pick_hit_s;
   logic [IDX_W-1:0]     pick_idx_s;
   logic [IDX_W-1:0]     next_ptr_s;
   logic [DATA_BITS-1:0] pick_data_s;

   function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
      return {{(N_REQ-1){1'b0}}, 1'b1} << i;
   endfunction

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr_r),
      .hit (pick_hit_s),
      .idx (pick_idx_s)
   );

   // Word of the requester the picker selected.
   always_comb begin
      pick_data_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx_s == IDX_W'(i)) begin
            pick_data_s = req_data[i*DATA_BITS +: DATA_BITS];
         end else begin
            pick_data_s = pick_data_s;
         end
      end
   end

   // Pointer to the requester after the current owner, wrapping at N_REQ.
   always_comb begin
      if (grant_id == IDX_LAST) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_id + IDX_W'(1);
      end
   end

   assign busy = (state_r != ST_IDLE);

   // Transaction FSM; pulse outputs default low every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= '0;
         cnt_r      <= '0;
         grant_id   <= '0;
         TxData     <= '0;
         TxReq      <= 1'b0;
         req_accept <= '0;
         req_done   <= '0;
         req_err    <= '0;
      end else begin
         TxReq      <= 1'b0;
         req_accept <= '0;
         req_done   <= '0;
         req_err    <= '0;
         case (state_r)
            ST_IDLE: begin
               // A busy UART blocks new grants; requests simply wait.
               if (!TxBusy && pick_hit_s) begin
                  TxData     <= pick_data_s;
                  grant_id   <= pick_idx_s;
                  TxReq      <= 1'b1;
                  req_accept <= to_onehot(pick_idx_s);
                  state_r    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_r   <= '0;
               state_r <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (TxBusy) begin
                  state_r <= ST_WAIT_DONE;
               end else if (cnt_r == CNT_LAST) begin
                  req_err  <= to_onehot(grant_id);
                  rr_ptr_r <= next_ptr_s;
                  state_r  <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!TxBusy) begin
                  req_done <= to_onehot(grant_id);
                  rr_ptr_r <= next_ptr_s;
                  state_r  <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of single transactions plus
// sequences for round-robin streaming, start timeout, busy blocking, reset and N_REQ=3 wrap.
module tb_uart_tx_arbiter;

   localparam int DW = 32;
   localparam int ST = 16;

   typedef struct {
      logic [3:0]  valid;
      int          busy_len;
      logic [1:0]  exp_grant;
      logic [31:0] exp_data;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    req_valid = 4'b0000;
   logic [4*DW-1:0] req_data;
   logic [3:0]    req_accept, req_done, req_err;
   logic [DW-1:0] TxData;
   logic          TxReq;
   logic          TxBusy = 1'b0;
   logic [1:0]    grant_id;
   logic          busy;

   logic [2:0]    req_valid3 = 3'b000;
   logic [3*DW-1:0] req_data3;
   logic [2:0]    req_accept3, req_done3, req_err3;
   logic [DW-1:0] TxData3;
   logic          TxReq3;
   logic          TxBusy3 = 1'b0;
   logic [1:0]    grant_id3;
   logic          busy3;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int busy_len = 3;
   bit never_start = 1'b0;
   bit force_busy = 1'b0;
   int busy_cnt = 0;
   int busy_cnt3 = 0;
   int k, waited, t0, last_done, any_flag;
   logic [31:0] lanes [4] = '{32'h1000_0000, 32'h2000_1111, 32'hA5A5_0001, 32'h3C3C_C3C3};
   int order4 [5] = '{0, 1, 2, 3, 0};
   int order3 [4] = '{0, 2, 0, 2};
   vec_t vecs [6];

   uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(ST)) u_dut4 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_accept(req_accept), .req_done(req_done), .req_err(req_err),
      .TxData(TxData), .TxReq(TxReq), .TxBusy(TxBusy), .grant_id(grant_id), .busy(busy)
   );

   uart_tx_arbiter #(.N_REQ(3), .START_TIMEOUT(ST)) u_dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid3), .req_data(req_data3),
      .req_accept(req_accept3), .req_done(req_done3), .req_err(req_err3),
      .TxData(TxData3), .TxReq(TxReq3), .TxBusy(TxBusy3), .grant_id(grant_id3), .busy(busy3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART model for the 4-requester instance: busy for busy_len cycles after TxReq.
   always @(posedge clk) begin
      if (force_busy) begin
         TxBusy   <= 1'b1;
         busy_cnt <= 0;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         TxBusy   <= (busy_cnt > 1);
      end else if (TxReq && !never_start) begin
         TxBusy   <= 1'b1;
         busy_cnt <= busy_len;
      end else begin
         TxBusy <= 1'b0;
      end
   end

   // UART model for the 3-requester instance: busy for two cycles after TxReq.
   always @(posedge clk) begin
      if (busy_cnt3 > 0) begin
         busy_cnt3 <= busy_cnt3 - 1;
         TxBusy3   <= (busy_cnt3 > 1);
      end else if (TxReq3) begin
         TxBusy3   <= 1'b1;
         busy_cnt3 <= 2;
      end else begin
         TxBusy3 <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   task automatic load_lanes();
      for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = lanes[i];
      for (int i = 0; i < 3; i++) req_data3[i*DW +: DW] = lanes[i];
   endtask

   task automatic wait_accept();
      int w;
      w = 0;
      @(negedge clk);
      while (req_accept === 4'b0000 && w < 20) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic wait_end();
      int w;
      w = 0;
      @(negedge clk);
      while (req_done === 4'b0000 && req_err === 4'b0000 && w < 60) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic run_txn(input vec_t v);
      int t_acc;
      logic [3:0] oh;
      oh = 4'b0001 << v.exp_grant;
      busy_len = v.busy_len;
      req_valid = v.valid;
      wait_accept();
      t_acc = cyc;
      check("accept", 32'(req_accept), 32'(oh));
      check("grant_id", 32'(grant_id), 32'(v.exp_grant));
      check("TxData", TxData, v.exp_data);
      check("TxReq_on", 32'(TxReq), 32'd1);
      check("busy_on", 32'(busy), 32'd1);
      req_valid = 4'b0000;
      req_data = ~req_data;
      @(negedge clk);
      check("TxReq_one_cycle", 32'(TxReq), 32'd0);
      check("accept_one_cycle", 32'(req_accept), 32'd0);
      wait_end();
      check("done", 32'(req_done), 32'(oh));
      check("err_none", 32'(req_err), 32'd0);
      check("done_latency", 32'(cyc - t_acc), 32'(v.busy_len + 2));
      check("TxData_hold", TxData, v.exp_data);
      load_lanes();
   endtask

   initial begin
      vecs[0] = '{4'b0100, 3, 2'd2, 32'hA5A5_0001};
      vecs[1] = '{4'b0101, 1, 2'd0, 32'h1000_0000};
      vecs[2] = '{4'b1001, 2, 2'd3, 32'h3C3C_C3C3};
      vecs[3] = '{4'b1111, 3, 2'd0, 32'h1000_0000};
      vecs[4] = '{4'b0011, 4, 2'd1, 32'h2000_1111};
      vecs[5] = '{4'b0001, 1, 2'd0, 32'h1000_0000};
      load_lanes();

      repeat (3) @(negedge clk);
      check("rst_accept", 32'(req_accept), 32'd0);
      check("rst_done", 32'(req_done), 32'd0);
      check("rst_err", 32'(req_err), 32'd0);
      check("rst_TxReq", 32'(TxReq), 32'd0);
      check("rst_TxData", TxData, 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_txn(vecs[i]);

      // All four requesting from reset: 0,1,2,3,0 back to back.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      busy_len = 2;
      req_valid = 4'b1111;
      k = 0;
      waited = 0;
      last_done = -100;
      while (k < 5 && waited < 100) begin
         @(negedge clk);
         waited++;
         if (req_done !== 4'b0000) last_done = cyc;
         if (req_accept !== 4'b0000) begin
            check("rr_order", 32'(oh_idx(req_accept)), 32'(order4[k]));
            check("rr_TxReq", 32'(TxReq), 32'd1);
            if (k > 0) check("back_to_back", 32'(cyc), 32'(last_done + 1));
            k++;
         end
      end
      check("rr_count", 32'(k), 32'd5);
      req_valid = 4'b0000;
      wait_end();

      // Start timeout: UART never goes busy.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      never_start = 1'b1;
      req_valid = 4'b0010;
      wait_accept();
      t0 = cyc;
      check("to_accept", 32'(req_accept), 32'b0010);
      req_valid = 4'b0000;
      any_flag = 0;
      waited = 0;
      @(negedge clk);
      while (req_err === 4'b0000 && waited < 40) begin
         if (req_done !== 4'b0000) any_flag = 1;
         @(negedge clk);
         waited++;
      end
      check("to_err", 32'(req_err), 32'b0010);
      check("to_latency", 32'(cyc - t0), 32'(ST + 1));
      check("to_no_done", 32'(any_flag), 32'd0);
      never_start = 1'b0;
      run_txn('{4'b0110, 1, 2'd2, 32'hA5A5_0001});

      // UART busy before the request: no grant until it falls.
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      req_valid = 4'b0001;
      any_flag = 0;
      repeat (4) begin
         @(negedge clk);
         if (req_accept !== 4'b0000) any_flag = 1;
      end
      check("busy_blocks", 32'(any_flag), 32'd0);
      force_busy = 1'b0;
      @(negedge clk);
      check("busy_fall_no_grant", 32'(req_accept), 32'd0);
      @(negedge clk);
      check("busy_fall_grant", 32'(req_accept), 32'b0001);
      req_valid = 4'b0000;
      wait_end();
      check("busy_fall_done", 32'(req_done), 32'b0001);

      // Reset while in WAIT_DONE: silent abandon, no grant while UART still busy.
      busy_len = 8;
      req_valid = 4'b0100;
      wait_accept();
      check("rw_accept", 32'(req_accept), 32'b0100);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      any_flag = 0;
      repeat (2) begin
         @(negedge clk);
         if (req_done !== 4'b0000 || req_err !== 4'b0000) any_flag = 1;
      end
      reset = 1'b0;
      check("rw_no_pulse", 32'(any_flag), 32'd0);
      check("rw_TxReq", 32'(TxReq), 32'd0);
      check("rw_TxData", TxData, 32'd0);
      check("rw_grant_id", 32'(grant_id), 32'd0);
      check("rw_busy", 32'(busy), 32'd0);
      check("rw_uart_busy", 32'(TxBusy), 32'd1);
      any_flag = 0;
      waited = 0;
      while (TxBusy === 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
         if (req_accept !== 4'b0000 || req_done !== 4'b0000) any_flag = 1;
      end
      check("rw_no_grant_busy", 32'(any_flag), 32'd0);
      check("rw_uart_idle", 32'(TxBusy), 32'd0);
      @(negedge clk);
      check("rw_regrant", 32'(req_accept), 32'b0100);
      req_valid = 4'b0000;
      wait_end();
      check("rw_done", 32'(req_done), 32'b0100);

      // N_REQ=3 with requesters 2 and 0: wrap 2 -> 0, grant_id stays below 3.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      req_valid3 = 3'b101;
      k = 0;
      waited = 0;
      any_flag = 0;
      while (k < 4 && waited < 100) begin
         @(negedge clk);
         waited++;
         if (grant_id3 > 2'd2) any_flag = 1;
         if (req_accept3 !== 3'b000) begin
            check("n3_order", 32'(oh_idx({1'b0, req_accept3})), 32'(order3[k]));
            k++;
         end
      end
      check("n3_count", 32'(k), 32'd4);
      check("n3_grant_range", 32'(any_flag), 32'd0);
      req_valid3 = 3'b000;
      repeat (10) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_BITS, 32, width of one UART word, taken from the shared package.
REQ-002 Parameter: N_REQ, 4, number of requesters; legal range 2..8, not required to be a power of two.
REQ-003 Parameter: START_TIMEOUT, 16, max cycles to wait for TxBusy to rise after a TxReq pulse.
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req_valid  input  N_REQ  per-requester transmit request, level.
REQ-007 Port: req_data  input  N_REQ*DATA_BITS  requester i word at [i*DATA_BITS +: DATA_BITS].
REQ-008 Port: req_accept  output  N_REQ  one-hot, one-cycle pulse: word captured.
REQ-009 Port: req_done  output  N_REQ  one-hot, one-cycle pulse: UART finished the word.
REQ-010 Port: req_err  output  N_REQ  one-hot, one-cycle pulse: start timeout, word dropped.
REQ-011 Port: TxData  output  DATA_BITS  registered word to the UART.
REQ-012 Port: TxReq  output  1  transmit strobe to the UART.
REQ-013 Port: TxBusy  input  1  UART transmitter busy.
REQ-014 Port: grant_id  output  $clog2(N_REQ)  index of the current owner, valid while busy=1.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-017 IDLE: with TxBusy=0 and any req_valid set, pick the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
REQ-018 On a pick at edge n: capture req_data[sel] into TxData, set grant_id=sel, go to ISSUE; req_accept[sel]=1 during cycle n+1 only.
REQ-019 IDLE with TxBusy=1 SHALL grant nothing; requests wait.
REQ-020 ISSUE: TxReq=1 for exactly one cycle, then go to WAIT_START with the timeout counter cleared.
REQ-021 WAIT_START: TxBusy=1 goes to WAIT_DONE; otherwise increment the counter; at count START_TIMEOUT-1 pulse req_err[grant_id] and go to IDLE.
REQ-022 WAIT_DONE: TxBusy=0 pulses req_done[grant_id] and goes to IDLE.
REQ-023 rr_ptr SHALL become (grant_id+1) mod N_REQ on each transition to IDLE, on both done and err.
REQ-024 TxData SHALL hold stable from capture until the next capture.
REQ-025 req_valid or req_data changes after acceptance SHALL have no effect on the current word.
REQ-026 A requester still asserting req_valid after done is a new request and gets no priority over others.
REQ-027 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester waits more than N_REQ-1 transactions.
REQ-028 At most one bit of req_accept, req_done and req_err SHALL be high in any cycle.
REQ-029 The earliest re-grant SHALL be the cycle after the done/err pulse (back-to-back, no idle gap).

Reset
REQ-030 While reset=1 at a clk edge, the block SHALL go to IDLE with TxReq=0, TxData=0, grant_id=0, rr_ptr=0, counter=0 and all pulse outputs 0.
REQ-031 Reset mid-transaction SHALL abandon it silently, with no done or err pulse.
REQ-032 After reset, no grant SHALL be made until TxBusy=0 (REQ-019).

Structure
REQ-033 Package uart_pkg SHALL hold DATA_BITS and the FSM state enum type.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: hit, index).
REQ-035 All outputs SHALL be registered except busy, which is decoded from the state.

Verification
REQ-036 Single request: req_valid=4'b0100, data 0xA5A5_0001, UART model busy 3 cycles -> one TxReq pulse, TxData=0xA5A5_0001, accept[2], then done[2].
REQ-037 All four valid from reset -> grants in order 0,1,2,3, then 0 again, with back-to-back TxReq and no gap beyond REQ-029.
REQ-038 Model never raises TxBusy -> req_err[grant] exactly START_TIMEOUT cycles after the WAIT_START entry, and rr_ptr advances.
REQ-039 TxBusy held high before the request -> no accept until TxBusy falls; grant follows on the next cycle.
REQ-040 Reset asserted in WAIT_DONE -> no done pulse, all outputs at reset values, and no grant while TxBusy=1.
REQ-041 N_REQ=3 with requesters 2 and 0 valid -> wrap from 2 to 0 is correct and grant_id never reaches 3.
